// File: rtl/exec_alu_mc.sv
// exec_alu_mc: execute-stage ALU producing a registered result and NZCV flags.
// Single-cycle ops (ADD/SUB/AND/ORR/EOR/MOVB) complete in one cycle. MUL runs
// an iterative shift-add that retires BPC multiplier bits per cycle and holds
// off new ops through in_ready while it iterates.
module exec_alu_mc #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_flags,
    output logic             busy
);

    localparam int ITERS = WIDTH / BPC;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_HOLD
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_ORR  = 3'b011,
        OP_EOR  = 3'b100,
        OP_MUL  = 3'b101,
        OP_MOVB = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;     // multiplicand, pre-shifted by BPC each iteration
    logic [WIDTH-1:0] mplier;    // multiplier, consumed BPC bits at a time from the bottom
    logic [WIDTH-1:0] acc;       // low WIDTH bits of the running product
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] mul_digit;
    logic [WIDTH-1:0] acc_next;

    // Packs {N,Z,C,V}; N and Z derive from the result for every op.
    function automatic logic [3:0] flags_of(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
        return {res[MSB], (res == '0), c, v};
    endfunction

    assign in_ready = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    // Single-cycle datapath; MUL and the reserved op fall through to zero here.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                sum     = {1'b0, src_a} + {1'b0, src_b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (src_a[MSB] == src_b[MSB]) & (alu_res[MSB] != src_a[MSB]);
            end
            OP_SUB: begin
                // Carry out of A + ~B + 1 is the inverted borrow.
                sum     = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (src_a[MSB] != src_b[MSB]) & (alu_res[MSB] != src_a[MSB]);
            end
            OP_AND:  alu_res = src_a & src_b;
            OP_ORR:  alu_res = src_a | src_b;
            OP_EOR:  alu_res = src_a ^ src_b;
            OP_MOVB: alu_res = src_b;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: the multiplicand is already aligned to this digit.
    assign mul_digit = WIDTH'(mplier[BPC-1:0]);
    assign acc_next  = acc + mcand * mul_digit;

    // Control FSM with registered outputs plus the MUL iteration registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            alu_flags <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (flush) begin
            // Kill whatever is in flight; result/flags keep their last values.
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            mcand     <= src_a;
                            mplier    <= src_b;
                            acc       <= '0;
                            cnt       <= '0;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            state     <= ST_MUL;
                        end else begin
                            result    <= alu_res;
                            alu_flags <= flags_of(alu_res, alu_c, alu_v);
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end
                    end else if (state == ST_HOLD && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << BPC;
                    mplier <= mplier >> BPC;
                    cnt    <= cnt + 1'b1;
                    // The last step writes the finished product straight to the output.
                    if (cnt == LAST) begin
                        result    <= acc_next;
                        alu_flags <= flags_of(acc_next, 1'b0, 1'b0);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_HOLD;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_alu_mc.sv
// Directed bench for exec_alu_mc: a BPC=1 instance carries most of the sequence,
// a BPC=4 instance checks the shorter multiply latency.
module tb_exec_alu_mc;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] AND_ = 3'b010;
    localparam logic [2:0] ORR  = 3'b011;
    localparam logic [2:0] EOR  = 3'b100;
    localparam logic [2:0] MUL  = 3'b101;
    localparam logic [2:0] MOVB = 3'b110;
    localparam logic [2:0] RSVD = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // BPC = 1 instance
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] src_a, src_b, result;
    logic [3:0]  alu_flags;

    // BPC = 4 instance
    logic        in_valid4, in_ready4, flush4, out_valid4, out_ready4, busy4;
    logic [2:0]  op4;
    logic [31:0] src_a4, src_b4, result4;
    logic [3:0]  alu_flags4;

    int total = 0;
    int bad   = 0;
    int cyc;
    int busy_cnt;

    exec_alu_mc #(.WIDTH(32), .BPC(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .alu_flags(alu_flags), .busy(busy)
    );

    exec_alu_mc #(.WIDTH(32), .BPC(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .op(op4), .src_a(src_a4), .src_b(src_b4), .flush(flush4),
        .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
        .alu_flags(alu_flags4), .busy(busy4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one single-cycle op (in_valid stays high) and checks the next-cycle output.
    task automatic do_op(input string tag, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [3:0] exp_nzcv);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        tick();
        check({tag, "_ov"},   32'(out_valid), 32'd1);
        check({tag, "_res"},  result, exp_res);
        check({tag, "_nzcv"}, 32'(alu_flags), 32'(exp_nzcv));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; op = ADD; src_a = '0; src_b = '0; flush = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; op4 = ADD; src_a4 = '0; src_b4 = '0; flush4 = 1'b0; out_ready4 = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_ov",       32'(out_valid), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_res",      result, 32'h0);
        check("rst_nzcv",     32'(alu_flags), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single-cycle ops, back-to-back with out_ready held high
        do_op("add_ovf",  ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
        do_op("sub_eq",   SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110);
        do_op("sub_brw",  SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1000);
        do_op("add_cry",  ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
        do_op("sub_ovf",  SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);
        do_op("and",      AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000);
        do_op("orr",      ORR,  32'h0000_000F, 32'h0000_0030, 32'h0000_003F, 4'b0000);
        do_op("movb",     MOVB, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 4'b0100);
        do_op("rsvd",     RSVD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100);
        in_valid = 1'b0;
        tick();
        check("idle_ov", 32'(out_valid), 32'd0);

        // MUL, BPC=1: in_valid during iteration must be ignored
        op = MUL; src_a = 32'h0001_0001; src_b = 32'h0000_FFFF; in_valid = 1'b1;
        tick();
        op = ADD; src_a = 32'h1; src_b = 32'h1;
        check("mul1_busy",     32'(busy), 32'd1);
        check("mul1_in_ready", 32'(in_ready), 32'd0);
        cyc = 1; busy_cnt = 0;
        while (!out_valid && cyc < 40) begin
            if (busy) busy_cnt++;
            if (cyc == 4) in_valid = 1'b0;
            tick();
            cyc++;
        end
        check("mul1_latency", 32'(cyc), 32'd33);
        check("mul1_busycnt", 32'(busy_cnt), 32'd32);
        check("mul1_res",     result, 32'hFFFF_FFFF);
        check("mul1_nzcv",    32'(alu_flags), 32'(4'b1000));
        check("mul1_busy_end", 32'(busy), 32'd0);
        tick();
        check("mul1_drain", 32'(out_valid), 32'd0);

        // MUL, BPC=4
        op4 = MUL; src_a4 = 32'h0001_0001; src_b4 = 32'h0000_FFFF; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        cyc = 1; busy_cnt = 0;
        while (!out_valid4 && cyc < 20) begin
            if (busy4) busy_cnt++;
            tick();
            cyc++;
        end
        check("mul4_latency", 32'(cyc), 32'd9);
        check("mul4_busycnt", 32'(busy_cnt), 32'd8);
        check("mul4_res",     result4, 32'hFFFF_FFFF);
        check("mul4_nzcv",    32'(alu_flags4), 32'(4'b1000));
        tick();

        // HOLD with out_ready low, then back-to-back EOR on release
        out_ready = 1'b0;
        op = ADD; src_a = 32'h10; src_b = 32'h20; in_valid = 1'b1;
        tick();
        check("hold_ov",   32'(out_valid), 32'd1);
        check("hold_res0", result, 32'h30);
        op = EOR; src_a = 32'hAAAA_5555; src_b = 32'hAAAA_5555;
        for (int i = 0; i < 5; i++) begin
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_res",      result, 32'h30);
            check("hold_ov_stay",  32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_ov",   32'(out_valid), 32'd1);
        check("b2b_res",  result, 32'h0);
        check("b2b_nzcv", 32'(alu_flags), 32'(4'b0100));
        tick();

        // Flush at iteration 10 of a MUL; in_valid during the flush is ignored
        op = MUL; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("fl_busy_pre", 32'(busy), 32'd1);
        flush = 1'b1;
        op = ADD; src_a = 32'h2; src_b = 32'h3; in_valid = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy",     32'(busy), 32'd0);
        check("fl_ov",       32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("fl_add_ov",   32'(out_valid), 32'd1);
        check("fl_add_res",  result, 32'h5);
        check("fl_add_nzcv", 32'(alu_flags), 32'h0);
        tick();
        check("fl_drain_ov", 32'(out_valid), 32'd0);
        repeat (30) tick();
        check("fl_no_stale_ov",  32'(out_valid), 32'd0);
        check("fl_no_stale_res", result, 32'h5);

        // Reset in the middle of a MUL
        op = MUL; src_a = 32'h3; src_b = 32'h7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("rm_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rm_ov",       32'(out_valid), 32'd0);
        check("rm_res",      result, 32'h0);
        check("rm_nzcv",     32'(alu_flags), 32'h0);
        check("rm_in_ready", 32'(in_ready), 32'd1);
        check("rm_busy",     32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
